regfile_sb: RTL and testbench
=============================

# regfile_sb

Parametrised MIPS general-purpose register file with two combinational read ports, one synchronous write port, and an integrated per-register busy scoreboard for the pipelined datapath. It sits between decode (operand read, hazard check, destination reservation) and writeback (result commit, reservation release). It replaces the fixed 32×32 single-cycle register file. Register 0 is hardwired to zero and is never busy.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, register address width; depth is 2**ADDR_W

Ports:
- clock  in  1  rising-edge clock; the only clock
- reset  in  1  synchronous, active-high reset
- read_reg1  in  ADDR_W  read port 1 address
- read_reg2  in  ADDR_W  read port 2 address
- read_data1  out  DATA_W  read port 1 data
- read_data2  out  DATA_W  read port 2 data
- read_busy1  out  1  read_reg1 has a pending producer
- read_busy2  out  1  read_reg2 has a pending producer
- RegWrite  in  1  writeback enable
- write_reg  in  ADDR_W  writeback address
- write_data  in  DATA_W  writeback data
- reserve  in  1  decode issues an instruction that will write dest_reg
- dest_reg  in  ADDR_W  destination to mark busy
- busy_count  out  ADDR_W+1  number of registers currently busy

## Operation
- Storage: 2**ADDR_W × DATA_W array plus a 2**ADDR_W busy-bit vector. Bit 0 of the vector is always 0.
- Write: at a clock edge with RegWrite=1 and write_reg≠0, the register at write_reg is loaded with write_data. Writes to register 0 are dropped.
- Read: read_dataN = array[read_regN], combinational. Address 0 always returns 0.
- Scoreboard set: at a clock edge with reserve=1 and dest_reg≠0, busy[dest_reg] is set to 1.
- Scoreboard clear: at a clock edge with RegWrite=1 and write_reg≠0, busy[write_reg] is cleared.
- Same register set and cleared in the same cycle: set wins. The older producer retires and the new one is pending.
- Set on a register that is already busy: no change (WAW is handled upstream).
- Clear on a register that is not busy: no change; the data write still occurs.
- read_busyN = busy[read_regN], combinational.
- busy_count is a registered population count of the busy vector:
  - +1 when a set lands on a non-busy register;
  - −1 when a clear lands on a busy register with no same-register set;
  - the net result is applied when a set and a clear land on different registers in the same cycle.

## Timing
- Reset: all registers 0, all busy bits 0, busy_count 0.
  - read_data1/2 read as 0 in the cycle after reset.
  - read_busy1/2 read as 0 in the cycle after reset.
- Reset asserted mid-operation overrides any simultaneous write, set or clear in that cycle.
- Write latency: data is visible on the read ports the cycle after the write edge, unless bypass is enabled (see Configuration).
- Reserve latency: read_busyN reflects a reservation the cycle after the reserve edge.
- busy_count updates on the same edge as the busy vector.
- No handshake; all inputs are sampled on every rising edge.

## Configuration
- REGFILE_BYPASS_EN defined: write-to-read forwarding is enabled. When RegWrite=1, write_reg≠0 and write_reg==read_regN in the same cycle:
  - read_dataN = write_data;
  - read_busyN = 0, unless reserve=1 with dest_reg==read_regN, in which case read_busyN follows the set-wins rule and shows 1.
- REGFILE_BYPASS_EN undefined: reads return the stored array and busy bits only. Same-cycle writeback is seen one cycle later, so decode must stall one extra cycle.

## Structure
- Package regfile_pkg holds:
  - DATA_W and ADDR_W defaults;
  - REG_ZERO constant (0);
  - the reg_addr_t and reg_data_t typedefs.
- Sub-module regfile_scoreboard holds the busy vector, set/clear priority, read_busy lookup and busy_count. The top level holds the data array, write logic and bypass muxes.

## Test plan
- Reset then read: after reset, read_reg1=20, read_reg2=0 → read_data1=0, read_data2=0, both busy flags 0, busy_count=0.
- Write/read: RegWrite=1, write_reg=9, write_data=64, then read_reg1=9 next cycle → read_data1=64.
- Write to register 0: RegWrite=1, write_reg=0, write_data=0xFFFFFFFF → read_data1 at address 0 stays 0.
- Reserve/retire: reserve with dest_reg=21 → read_busy1(21)=1 and busy_count=1. Then RegWrite to 21 with data 32 → busy 0, busy_count=0, read_data1=32.
- Simultaneous set and clear on reg 5 (already busy) → stays busy, busy_count unchanged. Set on 6 with clear on 5 → busy_count unchanged, busy[6]=1, busy[5]=0.
- Bypass (REGFILE_BYPASS_EN defined): RegWrite to 20 with data 16 and read_reg2=20 in the same cycle → read_data2=16 and read_busy2=0 in that cycle. Without the macro → read_data2 shows the old value in that cycle.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and types for the register file slice.
//   DATA_W_DEFAULT / ADDR_W_DEFAULT : default register width and address width
//   REG_ZERO                        : the hardwired-zero register index
//   reg_addr_t / reg_data_t         : address and data types at the default widths
package regfile_pkg;

  localparam int unsigned DATA_W_DEFAULT = 32;
  localparam int unsigned ADDR_W_DEFAULT = 5;

  localparam int unsigned REG_ZERO = 0;

  typedef logic [ADDR_W_DEFAULT-1:0] reg_addr_t;
  typedef logic [DATA_W_DEFAULT-1:0] reg_data_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy bits for the pipelined datapath.
//   clk_i, rst_i           : clock and synchronous active-high reset
//   set_i, set_addr_i      : decode reserves a destination (marks busy)
//   clr_i, clr_addr_i      : writeback retires a producer (clears busy)
//   rd_addr1_i/rd_addr2_i  : lookup addresses
//   rd_busy1_o/rd_busy2_o  : stored busy bit for each lookup address
//   busy_count_o           : registered population count of the busy vector
// A set and a clear on the same register in one cycle leave it busy: the old
// producer retires while the newly issued one is still pending.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              set_i,
  input  logic [ADDR_W-1:0] set_addr_i,
  input  logic              clr_i,
  input  logic [ADDR_W-1:0] clr_addr_i,
  input  logic [ADDR_W-1:0] rd_addr1_i,
  input  logic [ADDR_W-1:0] rd_addr2_i,
  output logic              rd_busy1_o,
  output logic              rd_busy2_o,
  output logic [ADDR_W:0]   busy_count_o
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [Depth-1:0] busy_q, busy_d;
  logic [ADDR_W:0]  count_q, count_d;

  logic set_hit, clr_hit, inc, dec;

  // Register zero can never be reserved or retired.
  assign set_hit = set_i & (set_addr_i != ADDR_W'(REG_ZERO));
  assign clr_hit = clr_i & (clr_addr_i != ADDR_W'(REG_ZERO));

  // Count tracks real transitions only, so it always equals popcount(busy_q).
  assign inc = set_hit & ~busy_q[set_addr_i];
  assign dec = clr_hit & busy_q[clr_addr_i] & ~(set_hit & (set_addr_i == clr_addr_i));

  always_comb begin
    busy_d = busy_q;
    if (clr_hit) begin
      busy_d[clr_addr_i] = 1'b0;
    end
    // Applied after the clear so a same-register set wins.
    if (set_hit) begin
      busy_d[set_addr_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_comb begin
    count_d = count_q;
    unique case ({inc, dec})
      2'b10:   count_d = count_q + {{ADDR_W{1'b0}}, 1'b1};
      2'b01:   count_d = count_q - {{ADDR_W{1'b0}}, 1'b1};
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  assign rd_busy1_o   = busy_q[rd_addr1_i];
  assign rd_busy2_o   = busy_q[rd_addr2_i];
  assign busy_count_o = count_q;

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: MIPS general-purpose register file with busy scoreboard.
//   clock, reset            : rising-edge clock, synchronous active-high reset
//   read_reg1/2             : combinational read addresses
//   read_data1/2            : read data (register 0 always reads 0)
//   read_busy1/2            : read register has a pending producer
//   RegWrite, write_reg,
//   write_data              : writeback port; also retires the busy bit
//   reserve, dest_reg       : decode marks dest_reg busy
//   busy_count              : number of busy registers
// Build option: define REGFILE_BYPASS_EN to forward same-cycle writeback data
// (and its busy release) onto the read ports.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT,
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  output logic              read_busy1,
  output logic              read_busy2,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic              reserve,
  input  logic [ADDR_W-1:0] dest_reg,
  output logic [ADDR_W:0]   busy_count
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [Depth];
  logic [DATA_W-1:0] mem_d [Depth];

  logic wr_en;
  logic sb_busy1, sb_busy2;

  assign wr_en = RegWrite & (write_reg != ADDR_W'(REG_ZERO));

  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[write_reg] = write_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  regfile_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk_i        (clock),
    .rst_i        (reset),
    .set_i        (reserve),
    .set_addr_i   (dest_reg),
    .clr_i        (RegWrite),
    .clr_addr_i   (write_reg),
    .rd_addr1_i   (read_reg1),
    .rd_addr2_i   (read_reg2),
    .rd_busy1_o   (sb_busy1),
    .rd_busy2_o   (sb_busy2),
    .busy_count_o (busy_count)
  );

  always_comb begin
    read_data1 = (read_reg1 == ADDR_W'(REG_ZERO)) ? '0 : mem_q[read_reg1];
    read_busy1 = sb_busy1;
`ifdef REGFILE_BYPASS_EN
    // Forwarded result retires the producer, unless a new one issues now.
    if (wr_en && (write_reg == read_reg1)) begin
      read_data1 = write_data;
      read_busy1 = reserve & (dest_reg == read_reg1);
    end
`endif
  end

  always_comb begin
    read_data2 = (read_reg2 == ADDR_W'(REG_ZERO)) ? '0 : mem_q[read_reg2];
    read_busy2 = sb_busy2;
`ifdef REGFILE_BYPASS_EN
    if (wr_en && (write_reg == read_reg2)) begin
      read_data2 = write_data;
      read_busy2 = reserve & (dest_reg == read_reg2);
    end
`endif
  end

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  read_reg1, read_reg2, write_reg, dest_reg;
  logic [31:0] read_data1, read_data2, write_data;
  logic        read_busy1, read_busy2, RegWrite, reserve;
  logic [5:0]  busy_count;

  regfile_sb dut (
    .clock      (clock),
    .reset      (reset),
    .read_reg1  (read_reg1),
    .read_reg2  (read_reg2),
    .read_data1 (read_data1),
    .read_data2 (read_data2),
    .read_busy1 (read_busy1),
    .read_busy2 (read_busy2),
    .RegWrite   (RegWrite),
    .write_reg  (write_reg),
    .write_data (write_data),
    .reserve    (reserve),
    .dest_reg   (dest_reg),
    .busy_count (busy_count)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // Reference model: plain arrays updated by the architectural rules.
  logic [31:0] m_mem [32];
  bit          m_busy [32];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(m_busy[i]);
    return n;
  endfunction

  function automatic logic [31:0] m_rdata(input logic [4:0] a);
`ifdef REGFILE_BYPASS_EN
    if (RegWrite && write_reg != 0 && write_reg == a) return write_data;
`endif
    return (a == 0) ? 32'h0 : m_mem[a];
  endfunction

  function automatic logic m_rbusy(input logic [4:0] a);
`ifdef REGFILE_BYPASS_EN
    if (RegWrite && write_reg != 0 && write_reg == a) return reserve && dest_reg == a;
`endif
    return m_busy[a];
  endfunction

  // Compare process: outputs are stable mid-cycle, check on the falling edge.
  always @(negedge clock) begin
    if (chk_en) begin
      chk("cmp_rd1", read_data1, m_rdata(read_reg1));
      chk("cmp_rd2", read_data2, m_rdata(read_reg2));
      chk("cmp_busy1", 32'(read_busy1), 32'(m_rbusy(read_reg1)));
      chk("cmp_busy2", 32'(read_busy2), 32'(m_rbusy(read_reg2)));
      chk("cmp_count", 32'(busy_count), 32'(m_count()));
    end
  end

  task automatic drive(input bit rst, input bit we, input logic [4:0] wr, input logic [31:0] wd,
                       input bit rsv, input logic [4:0] dst, input logic [4:0] r1,
                       input logic [4:0] r2);
    reset = rst; RegWrite = we; write_reg = wr; write_data = wd;
    reserve = rsv; dest_reg = dst; read_reg1 = r1; read_reg2 = r2;
    #1;
  endtask

  // Advance one edge and apply the same inputs to the model.
  task automatic tick();
    @(posedge clock);
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        m_mem[i] = 32'h0;
        m_busy[i] = 1'b0;
      end
    end else begin
      if (RegWrite && write_reg != 0) begin
        m_mem[write_reg] = write_data;
        m_busy[write_reg] = 1'b0;
      end
      if (reserve && dest_reg != 0) m_busy[dest_reg] = 1'b1;
    end
    #1;
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 20, 0);
    @(negedge clock);
    tick();
    chk_en = 1'b1;

    // Reset state; write 9 <= 64 issued this cycle.
    drive(0, 1, 9, 32'd64, 0, 0, 20, 0);
    chk("rst_rd1", read_data1, 32'd0);
    chk("rst_rd2", read_data2, 32'd0);
    chk("rst_busy1", 32'(read_busy1), 32'd0);
    chk("rst_busy2", 32'(read_busy2), 32'd0);
    chk("rst_count", 32'(busy_count), 32'd0);
    tick();

    // Read back 9; attempt write to register 0.
    drive(0, 1, 0, 32'hFFFF_FFFF, 0, 0, 9, 0);
    chk("wr_rd9", read_data1, 32'd64);
    tick();
    drive(0, 0, 0, 0, 1, 21, 0, 9);
    chk("r0_zero", read_data1, 32'd0);
    chk("r0_rd9", read_data2, 32'd64);
    tick();

    // Reserve 21 then retire it with 32.
    drive(0, 0, 0, 0, 0, 0, 21, 0);
    chk("rsv_busy21", 32'(read_busy1), 32'd1);
    chk("rsv_count", 32'(busy_count), 32'd1);
    tick();
    drive(0, 1, 21, 32'd32, 0, 0, 21, 0);
`ifdef REGFILE_BYPASS_EN
    chk("byp_rd21", read_data1, 32'd32);
    chk("byp_busy21", 32'(read_busy1), 32'd0);
`else
    chk("nobyp_rd21", read_data1, 32'd0);
    chk("nobyp_busy21", 32'(read_busy1), 32'd1);
`endif
    tick();
    drive(0, 0, 0, 0, 0, 0, 21, 0);
    chk("ret_busy21", 32'(read_busy1), 32'd0);
    chk("ret_count", 32'(busy_count), 32'd0);
    chk("ret_rd21", read_data1, 32'd32);
    tick();

    // Set and clear of busy reg 5 in one cycle, then set 6 / clear 5.
    drive(0, 0, 0, 0, 1, 5, 5, 0);
    tick();
    drive(0, 1, 5, 32'd7, 1, 5, 5, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 5, 0);
    chk("sc_busy5", 32'(read_busy1), 32'd1);
    chk("sc_count", 32'(busy_count), 32'd1);
    chk("sc_rd5", read_data1, 32'd7);
    tick();
    drive(0, 1, 5, 32'd8, 1, 6, 5, 6);
    tick();
    drive(0, 0, 0, 0, 0, 0, 5, 6);
    chk("x_busy5", 32'(read_busy1), 32'd0);
    chk("x_busy6", 32'(read_busy2), 32'd1);
    chk("x_count", 32'(busy_count), 32'd1);
    tick();

    // Same-cycle write to 20 read on port 2.
    drive(0, 1, 20, 32'd3, 0, 0, 0, 0);
    tick();
    drive(0, 1, 20, 32'd16, 0, 0, 0, 20);
`ifdef REGFILE_BYPASS_EN
    chk("byp_rd20", read_data2, 32'd16);
`else
    chk("nobyp_rd20", read_data2, 32'd3);
`endif
    chk("byp_busy20", 32'(read_busy2), 32'd0);
    tick();
    // Write and reserve 20 together: set wins on the read port too.
    drive(0, 1, 20, 32'd17, 1, 20, 0, 20);
`ifdef REGFILE_BYPASS_EN
    chk("byp_setwin", 32'(read_busy2), 32'd1);
`else
    chk("nobyp_setwin", 32'(read_busy2), 32'd0);
`endif
    tick();

    // Fill every register's busy bit.
    for (int i = 1; i < 32; i++) begin
      drive(0, 0, 0, 0, 1, 5'(i), 5'(i), 0);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 31, 0);
    chk("full_count", 32'(busy_count), 32'd31);
    tick();

    // Reset mid-operation overrides write and reserve.
    drive(1, 1, 10, 32'd99, 1, 7, 3, 4);
    tick();
    drive(0, 0, 0, 0, 0, 0, 10, 7);
    chk("mrst_rd10", read_data1, 32'd0);
    chk("mrst_busy7", 32'(read_busy2), 32'd0);
    chk("mrst_count", 32'(busy_count), 32'd0);
    tick();

    // Broad mixed traffic checked by the compare process.
    for (int i = 0; i < 200; i++) begin
      drive(0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      tick();
    end

    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clock);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
